// File: rtl/div_ctrl.sv
// div_ctrl: MIPS DIV/DIVU sequencer with a radix-2 restoring divider.
// Stalls IF..EX while busy; presents quotient on result_lo and remainder on result_hi.
module div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             flush,
    input  logic             pipe_hold,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state, state_n;
    logic [WIDTH-1:0] rem, quo, dvs, abs_a, abs_b, diff, rem_n, quo_n;
    logic [WIDTH:0] sh;
    logic [CW-1:0] counter;
    logic q_neg, r_neg, ge, accept, last;

    always_comb begin
        accept = state == IDLE && start && !flush;
        abs_a = (signed_div && opa[WIDTH-1]) ? -opa : opa;
        abs_b = (signed_div && opb[WIDTH-1]) ? -opb : opb;
        // The partial remainder stays below the divisor, so the difference fits in WIDTH bits.
        sh = {rem, quo[WIDTH-1]};
        ge = sh >= {1'b0, dvs};
        diff = sh[WIDTH-1:0] - dvs;
        rem_n = ge ? diff : sh[WIDTH-1:0];
        quo_n = {quo[WIDTH-2:0], ge};
        last = counter == CW'(WIDTH - 1);
        state_n = flush ? IDLE :
                  accept ? (opb == '0 ? DONE : BUSY) :
                  (state == BUSY && last) ? DONE :
                  (state == DONE && !pipe_hold) ? IDLE : state;
    end

    assign stall = accept || state == BUSY;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            counter   <= '0;
            result_lo <= '0;
            result_hi <= '0;
            div_zero  <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            rem       <= '0;
            quo       <= '0;
            dvs       <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
        end else begin
            state <= state_n;
            done  <= state_n == DONE;
            busy  <= state_n == BUSY;
            if (accept) begin
                rem      <= '0;
                quo      <= abs_a;
                dvs      <= abs_b;
                q_neg    <= signed_div && (opa[WIDTH-1] ^ opb[WIDTH-1]);
                r_neg    <= signed_div && opa[WIDTH-1];
                counter  <= '0;
                div_zero <= opb == '0;
                if (opb == '0) begin
                    result_lo <= '1;
                    result_hi <= opa;
                end
            end else if (state == BUSY && !flush) begin
                rem     <= rem_n;
                quo     <= quo_n;
                counter <= counter + 1'b1;
                if (last) begin
                    result_lo <= q_neg ? -quo_n : quo_n;
                    result_hi <= r_neg ? -rem_n : rem_n;
                end
            end
        end
    end
endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed checks of div_ctrl against hand-computed quotients, remainders and timing.
module tb_div_ctrl;
    logic        clk = 1'b0;
    logic        rst, start, signed_div, flush, pipe_hold;
    logic [31:0] opa, opb, result_lo, result_hi;
    logic        stall, busy, done, div_zero;
    int          checks = 0;
    int          errors = 0;

    div_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
        .opa(opa), .opb(opb), .flush(flush), .pipe_hold(pipe_hold),
        .stall(stall), .busy(busy), .done(done), .div_zero(div_zero),
        .result_lo(result_lo), .result_hi(result_hi)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one divide to DONE, checks latency, stall length and results, then returns to IDLE.
    task automatic do_div(input string tag, input logic sd, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi, input logic exp_dz,
                          input int exp_lat);
        int n = 0;
        int stall_cnt = 1;
        start = 1'b1; signed_div = sd; opa = a; opb = b;
        #1;
        chk({tag, " stall_accept"}, 32'(stall), 32'd1);
        tick();
        start = 1'b0;
        #1;
        while (!done && n < 40) begin
            if (stall) stall_cnt++;
            tick();
            n++;
        end
        chk({tag, " latency"}, n, exp_lat);
        chk({tag, " stall_cycles"}, stall_cnt, exp_lat + 1);
        chk({tag, " stall_done"}, 32'(stall), 32'd0);
        chk({tag, " lo"}, result_lo, exp_lo);
        chk({tag, " hi"}, result_hi, exp_hi);
        chk({tag, " dz"}, 32'(div_zero), 32'(exp_dz));
        tick();
        chk({tag, " done_clear"}, 32'(done), 32'd0);
    endtask

    initial begin
        int done_seen;
        rst = 1'b1; start = 1'b0; signed_div = 1'b0; flush = 1'b0; pipe_hold = 1'b0;
        opa = '0; opb = '0;
        tick(); tick();
        chk("rst lo", result_lo, 32'd0);
        chk("rst hi", result_hi, 32'd0);
        chk("rst flags", {28'd0, done, busy, div_zero, stall}, 32'd0);
        rst = 1'b0;
        tick();

        do_div("divu100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32);
        do_div("div-7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 32);
        do_div("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 32);
        do_div("divu_by0", 1'b0, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 1'b1, 0);

        // Flush 10 cycles into BUSY.
        start = 1'b1; signed_div = 1'b0; opa = 32'd1000; opb = 32'd3;
        tick();
        start = 1'b0;
        repeat (10) tick();
        chk("flush busy_before", 32'(busy), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("flush busy", 32'(busy), 32'd0);
        chk("flush stall", 32'(stall), 32'd0);
        chk("flush lo", result_lo, 32'hFFFFFFFF);
        chk("flush hi", result_hi, 32'h12345678);
        chk("flush dz", 32'(div_zero), 32'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) done_seen++;
            tick();
        end
        chk("flush no_done", done_seen, 0);

        // pipe_hold in DONE with start held high.
        start = 1'b1; signed_div = 1'b0; opa = 32'd1000; opb = 32'd3; pipe_hold = 1'b1;
        tick();
        for (int i = 0; i < 40 && !done; i++) tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) pipe_hold = 1'b0;
            chk($sformatf("hold done%0d", i), 32'(done), 32'd1);
            chk($sformatf("hold busy%0d", i), 32'(busy), 32'd0);
            chk($sformatf("hold lo%0d", i), result_lo, 32'd333);
            chk($sformatf("hold hi%0d", i), result_hi, 32'd1);
            tick();
        end
        chk("hold idle_done", 32'(done), 32'd0);
        chk("hold idle_busy", 32'(busy), 32'd0);
        chk("hold idle_stall", 32'(stall), 32'd1);
        start = 1'b0;
        #1;
        chk("hold stall_drop", 32'(stall), 32'd0);
        tick();

        do_div("div50_m5", 1'b1, 32'd50, 32'hFFFFFFFB, 32'hFFFFFFF6, 32'd0, 1'b0, 32);
        do_div("div-9_4", 1'b1, 32'hFFFFFFF7, 32'd4, 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0, 32);

        // Reset in the middle of a third op.
        start = 1'b1; signed_div = 1'b1; opa = 32'd7; opb = 32'd1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        chk("midrst lo", result_lo, 32'd0);
        chk("midrst hi", result_hi, 32'd0);
        chk("midrst flags", {28'd0, done, busy, div_zero, stall}, 32'd0);
        rst = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
